// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue FSM sitting upstream of an ALU with fixed latency ALU_LAT.
// Define ALU_SEQ_OPCHECK_EN to trap illegal opcodes locally (res_err=1, res_data=0).
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [4:0]  cmd_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op_code,
  output logic        alu_en,
  input  logic [63:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [4:0]  res_op,
  output logic        res_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
  } cmd_t;

`ifdef ALU_SEQ_OPCHECK_EN
  function automatic logic op_is_legal(input logic [4:0] op);
    case (op)
      5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000, 5'b01010: op_is_legal = 1'b1;
      default:                                op_is_legal = 1'b0;
    endcase
  endfunction
`endif

  // FIFO storage and pointers
  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full, empty, push, pop;
  cmd_t          head;
  logic          head_legal;

  // Sequencer state
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   alu_a_q, alu_a_d;
  logic [31:0]   alu_b_q, alu_b_d;
  logic [4:0]    alu_op_q, alu_op_d;
  logic [63:0]   res_data_q, res_data_d;
  logic [4:0]    res_op_q, res_op_d;
  logic          res_err_q, res_err_d;
  logic          take;

  // Full/empty use only registered pointers, so cmd_ready never depends on
  // this cycle's pop: a slot freed by a pop is usable from the next cycle.
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
`ifdef ALU_SEQ_OPCHECK_EN
    head_legal = op_is_legal(head.op);
`else
    head_legal = 1'b1;
`endif
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{a: cmd_a, b: cmd_b, op: cmd_op};
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    res_data_d = res_data_q;
    res_op_d   = res_op_q;
    res_err_d  = res_err_q;
    take       = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: take = !empty;
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          res_data_d = alu_out;
          res_op_d   = alu_op_q;
          res_err_d  = 1'b0;
          state_d    = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          take = !empty;
          if (empty) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // IDLE and a HOLD handshake share the same pop path; illegal commands
    // bypass the ALU pins entirely so they keep their previous value.
    if (take) begin
      pop = 1'b1;
      if (head_legal) begin
        alu_a_d  = head.a;
        alu_b_d  = head.b;
        alu_op_d = head.op;
        state_d  = S_ISSUE;
      end else begin
        res_data_d = '0;
        res_op_d   = head.op;
        res_err_d  = 1'b1;
        state_d    = S_HOLD;
      end
    end

    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_data_q <= '0;
      res_op_q   <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      res_data_q <= res_data_d;
      res_op_q   <= res_op_d;
      res_err_q  <= res_err_d;
    end
  end

  assign cmd_ready   = !full;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op_code = alu_op_q;
  assign alu_en      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign res_valid   = (state_q == S_HOLD);
  assign res_data    = res_data_q;
  assign res_op      = res_op_q;
  assign res_err     = res_err_q;
  assign busy        = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: ALU_LAT=1 instance with a vector table
// plus fill/stall/drain and mid-op reset sequences, and an ALU_LAT=3 instance.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ALU_LAT=1 instance
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [4:0]  cmd_op;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op_code;
  logic        alu_en;
  logic [63:0] alu_out;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic [4:0]  res_op;
  logic        res_err, busy;

  // ALU_LAT=3 instance
  logic        t3_cmd_valid, t3_cmd_ready;
  logic [31:0] t3_cmd_a, t3_cmd_b;
  logic [4:0]  t3_cmd_op;
  logic [31:0] t3_alu_a, t3_alu_b;
  logic [4:0]  t3_alu_op_code;
  logic        t3_alu_en;
  logic [63:0] t3_alu_out;
  logic        t3_res_valid, t3_res_ready;
  logic [63:0] t3_res_data;
  logic [4:0]  t3_res_op;
  logic        t3_res_err, t3_busy;

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code), .alu_en(alu_en),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_err(res_err), .busy(busy)
  );

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(t3_cmd_valid), .cmd_ready(t3_cmd_ready),
    .cmd_a(t3_cmd_a), .cmd_b(t3_cmd_b), .cmd_op(t3_cmd_op),
    .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_op_code(t3_alu_op_code), .alu_en(t3_alu_en),
    .alu_out(t3_alu_out),
    .res_valid(t3_res_valid), .res_ready(t3_res_ready),
    .res_data(t3_res_data), .res_op(t3_res_op), .res_err(t3_res_err), .busy(t3_busy)
  );

  // Behavioural ALU: result pipelined ALU_LAT stages behind the enable cycle,
  // garbage when not enabled so early/late capture is visible.
  function automatic logic [63:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op);
    logic [63:0] ea, eb;
    ea = {32'd0, a};
    eb = {32'd0, b};
    case (op)
      5'b00001: alu_f = ea + eb;
      5'b00010: alu_f = ea - eb;
      5'b00011: alu_f = ea * eb;
      5'b00100: alu_f = ea << 1;
      5'b00101: alu_f = ea >> 1;
      5'b00110: alu_f = ea & eb;
      5'b00111: alu_f = ea | eb;
      5'b01000: alu_f = ea + 64'd1;
      5'b01010: alu_f = ea - 64'd1;
      default:  alu_f = {b, a};
    endcase
  endfunction

  logic [63:0] p1;
  logic [63:0] q3 [3];
  always @(posedge clk) begin
    p1    <= alu_en ? alu_f(alu_a, alu_b, alu_op_code) : 64'hDEAD_DEAD_DEAD_DEAD;
    q3[0] <= t3_alu_en ? alu_f(t3_alu_a, t3_alu_b, t3_alu_op_code) : 64'hDEAD_DEAD_DEAD_DEAD;
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign alu_out    = p1;
  assign t3_alu_out = q3[2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  vec_t vecs [11];

  task automatic run_vec(input int i);
    int lat;
    int en_cnt;
    cmd_a     = vecs[i].a;
    cmd_b     = vecs[i].b;
    cmd_op    = vecs[i].op;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lat       = 1;
    en_cnt    = 0;
    while (!res_valid && lat < 20) begin
      if (alu_en) en_cnt++;
      tick();
      lat++;
    end
    chk($sformatf("vec%0d_valid", i), res_valid, 1);
    chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
    chk($sformatf("vec%0d_en_cycles", i), en_cnt, vecs[i].exp_en);
    chk($sformatf("vec%0d_data", i), res_data, vecs[i].exp_data);
    chk($sformatf("vec%0d_op", i), res_op, vecs[i].op);
    chk($sformatf("vec%0d_err", i), res_err, vecs[i].exp_err);
    tick();
    chk($sformatf("vec%0d_idle_busy", i), busy, 0);
  endtask

  initial begin : main
    int acc;
    int got;
    int last;
    int lat;
    int en_cnt;
    logic seen;
    logic [63:0] drain_exp [5];

    vecs[0] = '{32'd5,          32'd3,          5'b00001, 64'd8,                   1'b0, 4, 2};
    vecs[1] = '{32'hFFFF_FFFF,  32'd2,          5'b00011, 64'h1_FFFF_FFFE,         1'b0, 4, 2};
    vecs[2] = '{32'd3,          32'd5,          5'b00010, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4, 2};
    vecs[3] = '{32'h8000_0001,  32'd0,          5'b00100, 64'h1_0000_0002,         1'b0, 4, 2};
    vecs[4] = '{32'h8000_0001,  32'd0,          5'b00101, 64'h4000_0000,           1'b0, 4, 2};
    vecs[5] = '{32'hF0F0_F0F0,  32'hFF00_FF00,  5'b00110, 64'hF000_F000,           1'b0, 4, 2};
    vecs[6] = '{32'hF0F0_F0F0,  32'hFF00_FF00,  5'b00111, 64'hFFF0_FFF0,           1'b0, 4, 2};
    vecs[7] = '{32'hFFFF_FFFF,  32'd0,          5'b01000, 64'h1_0000_0000,         1'b0, 4, 2};
    vecs[8] = '{32'd0,          32'd0,          5'b01010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4, 2};
`ifdef ALU_SEQ_OPCHECK_EN
    vecs[9]  = '{32'h11, 32'h22, 5'b01001, 64'd0, 1'b1, 2, 0};
    vecs[10] = '{32'h33, 32'h44, 5'b00000, 64'd0, 1'b1, 2, 0};
`else
    vecs[9]  = '{32'h11, 32'h22, 5'b01001, 64'h0000_0022_0000_0011, 1'b0, 4, 2};
    vecs[10] = '{32'h33, 32'h44, 5'b00000, 64'h0000_0044_0000_0033, 1'b0, 4, 2};
`endif

    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_a        = '0;
    cmd_b        = '0;
    cmd_op       = '0;
    res_ready    = 1'b0;
    t3_cmd_valid = 1'b0;
    t3_cmd_a     = '0;
    t3_cmd_b     = '0;
    t3_cmd_op    = '0;
    t3_res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op_code", alu_op_code, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_op", res_op, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Fill: park one result in HOLD, then offer 6 commands back-to-back.
    res_ready = 1'b0;
    cmd_a = 32'd100; cmd_b = 32'd1; cmd_op = 5'b00001;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("fill_hold_valid", res_valid, 1);
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      cmd_a = 32'(k); cmd_b = 32'd1000; cmd_op = 5'b00001;
      cmd_valid = 1'b1;
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("fill_accepted", acc, 4);
    chk("fill_ready_low", cmd_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d_data", k), res_data, 64'd101);
      chk($sformatf("stall%0d_valid", k), res_valid, 1);
    end
    chk("stall_ready_low", cmd_ready, 0);

    drain_exp[0] = 64'd101;
    drain_exp[1] = 64'd1000;
    drain_exp[2] = 64'd1001;
    drain_exp[3] = 64'd1002;
    drain_exp[4] = 64'd1003;
    res_ready = 1'b1;
    got  = 0;
    last = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (cyc == 1) chk("ready_after_pop", cmd_ready, 1);
      if (res_valid) begin
        chk($sformatf("drain%0d_data", got), res_data, drain_exp[got]);
        if (got > 0) chk($sformatf("drain%0d_spacing", got), cyc - last, 3);
        last = cyc;
        got++;
      end
      tick();
    end
    chk("drain_count", got, 5);
    chk("drain_idle_busy", busy, 0);

    // ALU_LAT=3: result at N+6, enable held for ISSUE + 3 WAIT cycles.
    t3_cmd_a = 32'd10; t3_cmd_b = 32'd3; t3_cmd_op = 5'b00010;
    t3_cmd_valid = 1'b1;
    t3_res_ready = 1'b1;
    tick();
    t3_cmd_valid = 1'b0;
    lat    = 1;
    en_cnt = 0;
    while (!t3_res_valid && lat < 30) begin
      if (t3_alu_en) en_cnt++;
      tick();
      lat++;
    end
    chk("lat3_valid", t3_res_valid, 1);
    chk("lat3_latency", lat, 6);
    chk("lat3_en_cycles", en_cnt, 4);
    chk("lat3_data", t3_res_data, 64'd7);
    chk("lat3_op", t3_res_op, 5'b00010);
    tick();
    chk("lat3_idle_busy", t3_busy, 0);

    // Reset during WAIT with a second command still queued.
    res_ready = 1'b0;
    cmd_a = 32'd7; cmd_b = 32'd2; cmd_op = 5'b00001;
    cmd_valid = 1'b1;
    tick();
    cmd_a = 32'd1; cmd_b = 32'd1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_wait_en", alu_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_alu_a", alu_a, 0);
    chk("mrst_alu_b", alu_b, 0);
    chk("mrst_alu_op_code", alu_op_code, 0);
    chk("mrst_alu_en", alu_en, 0);
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_res_data", res_data, 0);
    chk("mrst_res_op", res_op, 0);
    chk("mrst_res_err", res_err, 0);
    chk("mrst_busy", busy, 0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (res_valid || alu_en || busy) seen = 1'b1;
    end
    chk("mrst_no_activity", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end that sits directly upstream of `alu`. It buffers operand/opcode commands from a valid/ready producer in a small FIFO and issues them one at a time on the ALU's `a`/`b`/`op_code`/`en` pins. It waits the ALU's fixed latency, captures the 64-bit `out`, and presents it on a valid/ready result port. Illegal opcodes are trapped locally and never reach the ALU.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `ALU_LAT`, 1: cycles from the `alu_en` issue cycle to a valid `alu_out`; ≥1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_a` in 32: operand a.
- `cmd_b` in 32: operand b.
- `cmd_op` in 5: opcode.
- `alu_a` out 32: to ALU `a`.
- `alu_b` out 32: to ALU `b`.
- `alu_op_code` out 5: to ALU `op_code`.
- `alu_en` out 1: to ALU `en`.
- `alu_out` in 64: from ALU `out`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 64: captured result.
- `res_op` out 5: opcode that produced `res_data`.
- `res_err` out 1: result belongs to a trapped illegal opcode.
- `busy` out 1: high when FSM is not IDLE or FIFO is non-empty.

## Operation
- Legal opcodes: 00001 add, 00010 sub, 00011 mul, 00100 shl1, 00101 shr1, 00110 and, 00111 or, 01000 inc, 01010 dec. All other opcodes are illegal.
- FIFO push occurs on `cmd_valid && cmd_ready`. `cmd_ready = !full`, decoded from registered pointers, with no combinational path from `cmd_valid`.
- Push while full is refused. A simultaneous pop does not free a slot for a push in the same cycle.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full and empty are decoded from the MSB and index compare.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE, FIFO non-empty: pop the head into operand/op registers.
  - Legal opcode: go to ISSUE.
  - Illegal opcode: go to HOLD with `res_data`=0, `res_err`=1.
- ISSUE: one cycle. `alu_en`=1, and the `alu_*` pins drive the registered command. Load the wait counter with ALU_LAT−1. Go to WAIT.
- WAIT: `alu_en` stays 1 and operands stay stable. The counter decrements each cycle.
  - At counter 0, capture `alu_out` into `res_data` with `res_err`=0 and go to HOLD.
- HOLD: `res_valid`=1. `res_data`, `res_op` and `res_err` are stable until handshake.
  - Handshake with FIFO non-empty: pop the next command directly (to ISSUE or to HOLD as in IDLE).
  - Handshake with FIFO empty: go to IDLE.
- `alu_en`=0 in IDLE and HOLD. The `alu_*` operand pins hold their last value.
- `res_data` passes `alu_out` through verbatim. There is no width conversion.
- Reset, including mid-operation: FIFO is emptied and any in-flight command is dropped with no result. FSM goes to IDLE.

## Timing
- Reset values: `cmd_ready`=1, `alu_a`=0, `alu_b`=0, `alu_op_code`=0, `alu_en`=0, `res_valid`=0, `res_data`=0, `res_op`=0, `res_err`=0, `busy`=0.
- Command accepted at cycle N into an empty, idle block:
  - Pop at the end of cycle N+1.
  - ISSUE in cycle N+2.
  - WAIT in cycles N+3 … N+2+ALU_LAT.
  - `res_valid` from cycle N+3+ALU_LAT. This is N+4 for ALU_LAT=1.
- Illegal opcode accepted at cycle N: `res_valid` at N+2. `alu_en` is never raised for it.
- Back-to-back legal commands with `res_ready` held high: one result every ALU_LAT+2 cycles.
- `cmd_ready` deasserts in the cycle after the DEPTH-th unpopped push.

## Configuration
- `ALU_SEQ_OPCHECK_EN` defined: illegal opcodes are trapped as described, with `res_err` driven.
- `ALU_SEQ_OPCHECK_EN` undefined: every opcode is issued to the ALU and `res_data` = `alu_out`. `res_err` is tied to 0.

## Test plan
- Single add, a=5, b=3, op=00001, `res_ready`=1 → `alu_en` high at N+2..N+3; `res_valid`, `res_data`=8, `res_op`=00001 at N+4.
- Mul, a=0xFFFFFFFF, b=2 → `res_data`=0x1_FFFFFFFE.
- With `res_ready`=0, push 6 commands back-to-back → 4 accepted; `cmd_ready`=0 until a pop. `res_data` stays stable for 5 stalled cycles, then results drain in order.
- op=01001, macro defined → `res_err`=1, `res_data`=0 at N+2, `alu_en` never asserted. Macro undefined → the command is issued and `res_err`=0.
- `rst` pulsed during WAIT → next cycle all outputs at reset values, `busy`=0, and no `res_valid` for the dropped command.
- ALU_LAT=3 build, sub a=10, b=3 → `res_valid` with `res_data` equal to the ALU's output at N+6.
